// File: rtl/prefetch_fetch_unit.sv
// rtl/prefetch_fetch_unit.sv - instruction prefetch unit with credit-based show-ahead buffer
module prefetch_fetch_unit #(
    parameter int              DATA_W   = 16,
    parameter int              PC_W     = 8,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       run,
    input  logic                       redirect,
    input  logic [PC_W-1:0]            redirect_pc,
    output logic                       imem_req,
    output logic [PC_W-1:0]            imem_addr,
    input  logic [DATA_W-1:0]          imem_rdata,
    output logic [DATA_W-1:0]          instr_out,
    output logic [PC_W-1:0]            instr_pc,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [PC_W-1:0]   fetch_pc;
    logic [PC_W-1:0]   req_pc;
    logic [CW-1:0]     count_q;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic              inflight;
    logic              killed;
    logic [CW:0]       used;
    logic              push;
    logic              pop;

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PC_W-1:0]   pc_mem   [DEPTH];

    // An outstanding request already owns a slot, so it counts against capacity.
    assign used     = {1'b0, count_q} + {{CW{1'b0}}, inflight};
    assign imem_req = reset & run & ~redirect & (used < DEPTH_C);
    assign imem_addr = fetch_pc;

    assign push = inflight & ~killed & ~redirect;
    assign pop  = instr_valid & instr_ready & ~redirect;

    assign instr_valid = (count_q != '0);
    assign instr_out   = instr_valid ? data_mem[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? pc_mem[rd_ptr]   : '0;
    assign count       = count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            count_q  <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            inflight <= 1'b0;
            killed   <= 1'b0;
        end else begin
            inflight <= imem_req;
            // A request leaving in a redirect cycle would belong to the old stream.
            killed   <= redirect & imem_req;
            if (imem_req) begin
                req_pc <= fetch_pc;
            end
            if (redirect) begin
                fetch_pc <= redirect_pc;
                count_q  <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (imem_req) begin
                    fetch_pc <= fetch_pc + 1'b1;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]   <= req_pc;
        end
    end
endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// tb/tb_prefetch_fetch_unit.sv - directed and randomized bench for prefetch_fetch_unit
module tb_prefetch_fetch_unit;
    localparam int DW = 16;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          run = 1'b0;
    logic          redirect = 1'b0;
    logic [PW-1:0] redirect_pc = '0;
    logic          instr_ready = 1'b0;
    logic          ready2 = 1'b0;

    logic          imem_req, imem_req2;
    logic [PW-1:0] imem_addr, imem_addr2;
    logic [DW-1:0] imem_rdata = 16'hDEAD;
    logic [DW-1:0] imem_rdata2 = 16'hDEAD;
    logic [DW-1:0] instr_out, instr_out2;
    logic [PW-1:0] instr_pc, instr_pc2;
    logic          instr_valid, instr_valid2;
    logic [2:0]    count, count2;

    int pass_cnt = 0;
    int total_cnt = 0;

    prefetch_fetch_unit #(.DATA_W(DW), .PC_W(PW), .DEPTH(4), .RESET_PC(8'h00)) dut (
        .clk(clk), .reset(reset), .run(run), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .count(count)
    );

    prefetch_fetch_unit #(.DATA_W(DW), .PC_W(PW), .DEPTH(4), .RESET_PC(8'hFE)) dut2 (
        .clk(clk), .reset(reset), .run(run), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .instr_out(instr_out2), .instr_pc(instr_pc2), .instr_valid(instr_valid2),
        .instr_ready(ready2), .count(count2)
    );

    always #5 clk = ~clk;

    // memory[a] = 0x1000 + a, one-cycle read latency; junk when not requested
    always @(posedge clk) begin
        imem_rdata  <= imem_req  ? 16'h1000 + 16'(imem_addr)  : 16'hDEAD;
        imem_rdata2 <= imem_req2 ? 16'h1000 + 16'(imem_addr2) : 16'hDEAD;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got no summary, need completion");
        $fatal(1, "timeout");
    end

    task automatic restart(input logic rdy);
        @(negedge clk);
        reset = 1'b0; redirect = 1'b0; run = 1'b1; instr_ready = rdy; ready2 = 1'b0;
        #1;
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0; run = 1'b1; instr_ready = 1'b1;
        #1;
        total_cnt++;
        if (imem_req !== 1'b0) $display("FAIL reset_req: got %b need 0", imem_req); else pass_cnt++;
        total_cnt++;
        if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b need 0", instr_valid); else pass_cnt++;
        total_cnt++;
        if (instr_out !== 16'h0) $display("FAIL reset_out: got %h need 0000", instr_out); else pass_cnt++;
        total_cnt++;
        if (instr_pc !== 8'h0) $display("FAIL reset_pc: got %h need 00", instr_pc); else pass_cnt++;
        total_cnt++;
        if (count !== 3'd0) $display("FAIL reset_count: got %0d need 0", count); else pass_cnt++;
    endtask

    task automatic test_fill();
        bit er [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        int ec [6] = '{0, 0, 1, 2, 3, 4};
        restart(1'b0);
        for (int c = 0; c < 6; c++) begin
            total_cnt++;
            if (imem_req !== er[c]) $display("FAIL fill_req c%0d: got %b need %b", c, imem_req, er[c]); else pass_cnt++;
            if (er[c]) begin
                total_cnt++;
                if (imem_addr !== 8'(c)) $display("FAIL fill_addr c%0d: got %h need %h", c, imem_addr, 8'(c)); else pass_cnt++;
            end
            total_cnt++;
            if (count !== 3'(ec[c])) $display("FAIL fill_count c%0d: got %0d need %0d", c, count, ec[c]); else pass_cnt++;
            if (c < 5) step();
        end
        total_cnt++;
        if ({instr_valid, instr_pc, instr_out} !== {1'b1, 8'h00, 16'h1000})
            $display("FAIL fill_head: got v=%b pc=%h out=%h need v=1 pc=00 out=1000", instr_valid, instr_pc, instr_out);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        restart(1'b1);
        for (int c = 0; c < 12; c++) begin
            int e = c - 2;
            total_cnt++;
            if (c < 2) begin
                if (instr_valid !== 1'b0) $display("FAIL stream_latency c%0d: got valid=%b need 0", c, instr_valid); else pass_cnt++;
            end else begin
                if ({instr_valid, instr_pc, instr_out} !== {1'b1, 8'(e), 16'h1000 + 16'(e)})
                    $display("FAIL stream c%0d: got v=%b pc=%h out=%h need v=1 pc=%h out=%h",
                             c, instr_valid, instr_pc, instr_out, 8'(e), 16'h1000 + 16'(e));
                else pass_cnt++;
            end
            step();
        end
    endtask

    task automatic test_redirect();
        restart(1'b0);
        repeat (4) step();
        total_cnt++;
        if (count !== 3'd3) $display("FAIL redir_pre_count: got %0d need 3", count); else pass_cnt++;
        redirect = 1'b1; redirect_pc = 8'h40;
        #1;
        total_cnt++;
        if (imem_req !== 1'b0) $display("FAIL redir_req_same_cycle: got %b need 0", imem_req); else pass_cnt++;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        total_cnt++;
        if ({count, instr_valid} !== {3'd0, 1'b0}) $display("FAIL redir_flush: got count=%0d v=%b need 0 0", count, instr_valid); else pass_cnt++;
        total_cnt++;
        if ({imem_req, imem_addr} !== {1'b1, 8'h40}) $display("FAIL redir_first_req: got req=%b addr=%h need 1 40", imem_req, imem_addr); else pass_cnt++;
        step();
        total_cnt++;
        if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 8'h41})
            $display("FAIL redir_c2: got v=%b req=%b addr=%h need 0 1 41", instr_valid, imem_req, imem_addr);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({instr_valid, instr_pc, instr_out} !== {1'b1, 8'h40, 16'h1040})
            $display("FAIL redir_first_out: got v=%b pc=%h out=%h need 1 40 1040", instr_valid, instr_pc, instr_out);
        else pass_cnt++;
    endtask

    task automatic test_pc_wrap();
        logic [PW-1:0] ep [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        restart(1'b0);
        repeat (5) step();
        total_cnt++;
        if (count2 !== 3'd4) $display("FAIL wrap_count: got %0d need 4", count2); else pass_cnt++;
        ready2 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            total_cnt++;
            if ({instr_valid2, instr_pc2, instr_out2} !== {1'b1, ep[k], 16'h1000 + 16'(ep[k])})
                $display("FAIL wrap_seq k%0d: got v=%b pc=%h out=%h need 1 %h %h",
                         k, instr_valid2, instr_pc2, instr_out2, ep[k], 16'h1000 + 16'(ep[k]));
            else pass_cnt++;
            @(negedge clk);
        end
        ready2 = 1'b0;
    endtask

    task automatic test_mid_reset();
        restart(1'b0);
        repeat (5) step();
        total_cnt++;
        if (count !== 3'd4) $display("FAIL mrst_full: got %0d need 4", count); else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++;
        if ({imem_req, instr_valid, instr_out, instr_pc, count} !== {1'b0, 1'b0, 16'h0, 8'h0, 3'd0})
            $display("FAIL mrst_async: got req=%b v=%b out=%h pc=%h cnt=%0d need all 0",
                     imem_req, instr_valid, instr_out, instr_pc, count);
        else pass_cnt++;
        @(negedge clk);
        instr_ready = 1'b1; reset = 1'b1;
        #1;
        total_cnt++;
        if ({imem_req, imem_addr} !== {1'b1, 8'h00}) $display("FAIL mrst_restart: got req=%b addr=%h need 1 00", imem_req, imem_addr); else pass_cnt++;
        step();
        step();
        total_cnt++;
        if ({instr_valid, instr_pc, instr_out} !== {1'b1, 8'h00, 16'h1000})
            $display("FAIL mrst_first_out: got v=%b pc=%h out=%h need 1 00 1000", instr_valid, instr_pc, instr_out);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [PW-1:0] exp_pc = 8'h00;
        int pops = 0;
        restart(1'b0);
        for (int i = 0; i < 10000; i++) begin
            run         = ($urandom_range(0, 9) < 8);
            instr_ready = ($urandom_range(0, 9) < 6);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = PW'($urandom);
            #1;
            total_cnt++;
            if (count > 3'd4) $display("FAIL rand_overflow i%0d: got count=%0d need <=4", i, count); else pass_cnt++;
            if (instr_valid && instr_ready && !redirect) begin
                total_cnt++;
                if ({instr_pc, instr_out} !== {exp_pc, 16'h1000 + 16'(exp_pc)})
                    $display("FAIL rand_pop i%0d: got pc=%h out=%h need pc=%h out=%h",
                             i, instr_pc, instr_out, exp_pc, 16'h1000 + 16'(exp_pc));
                else pass_cnt++;
                exp_pc = exp_pc + 1'b1;
                pops++;
            end
            if (redirect) exp_pc = redirect_pc;
            @(negedge clk);
        end
        redirect = 1'b0;
        total_cnt++;
        if (pops < 1000) $display("FAIL rand_throughput: got %0d pops need >=1000", pops); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stream();
        test_redirect();
        test_pc_wrap();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/prefetch_fetch_unit.md
PREFETCH_FETCH_UNIT -- requirements
Module: prefetch_fetch_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning instruction word width.
REQ-002 SHALL have parameter PC_W, default 8, meaning PC and instruction-memory address width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning prefetch buffer entries; a power of 2 and at least 2.
REQ-004 SHALL have parameter RESET_PC, default 0, meaning the PC value loaded at reset.
REQ-005 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port run, input, 1 bit: fetch enable; when low, no new requests are issued.
REQ-008 SHALL have port redirect, input, 1 bit: branch/jump taken this cycle.
REQ-009 SHALL have port redirect_pc, input, PC_W bits: target PC, sampled when redirect=1.
REQ-010 SHALL have port imem_req, output, 1 bit: read request to instruction memory.
REQ-011 SHALL have port imem_addr, output, PC_W bits: read address, equal to the current fetch PC.
REQ-012 SHALL have port imem_rdata, input, DATA_W bits: read data, valid exactly one cycle after imem_req.
REQ-013 SHALL have port instr_out, output, DATA_W bits: head-of-buffer instruction.
REQ-014 SHALL have port instr_pc, output, PC_W bits: PC of instr_out.
REQ-015 SHALL have port instr_valid, output, 1 bit: buffer non-empty.
REQ-016 SHALL have port instr_ready, input, 1 bit: core accepts the head this cycle.
REQ-017 SHALL have port count, output, $clog2(DEPTH)+1 bits: number of buffered entries.

Function
REQ-018 SHALL assert imem_req combinationally when run=1, redirect=0, and count + inflight < DEPTH, where inflight = imem_req registered from the previous cycle.
REQ-019 SHALL increment the fetch PC by 1 on every cycle imem_req=1, wrapping modulo 2^PC_W (e.g. 0xFF -> 0x00 for PC_W=8).
REQ-020 SHALL, when inflight=1 and the response is not killed, write {PC of request, imem_rdata} into the buffer tail in the same cycle the data arrives.
REQ-021 SHALL pop the head on a rising edge where instr_valid=1 and instr_ready=1; a simultaneous push and pop SHALL leave count unchanged.
REQ-022 SHALL present the buffer show-ahead: instr_out/instr_pc reflect the head combinationally; when empty, both SHALL be driven to 0.
REQ-023 SHALL never overflow: the credit rule in REQ-018 guarantees a push is never attempted when count=DEPTH.
REQ-024 SHALL never underflow: instr_ready while instr_valid=0 SHALL be ignored.
REQ-025 On redirect=1, at the next edge, the unit SHALL:
  - load the fetch PC with redirect_pc;
  - empty the buffer (count=0);
  - mark any inflight response as killed.
  A pop or push in the same cycle SHALL be discarded.
REQ-026 SHALL not raise imem_req in the redirect cycle; the first request at redirect_pc SHALL be issued the following cycle, provided run=1.
REQ-027 SHALL, on a response marked killed, drop imem_rdata with no buffer write.
REQ-028 SHALL, when run falls, stop new requests; an inflight response SHALL still be buffered; buffered entries SHALL remain poppable.
REQ-029 SHALL use circular read/write pointers of $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0.

Reset
REQ-030 SHALL, on reset=0, immediately and asynchronously set: fetch PC=RESET_PC, count=0, pointers=0, inflight=0, killed=0.
REQ-031 SHALL hold imem_req=0, instr_valid=0, instr_out=0 and instr_pc=0 while reset=0.
REQ-032 SHALL discard any request issued before a mid-operation reset; its response SHALL not be buffered.
REQ-033 SHALL release reset synchronously: the first request is possible on the first rising clk edge after reset returns high.

Verification
REQ-034 Reset release, run=1, instr_ready=0, memory[i]=0x1000+i -> requests at 0,1,2,3; count reaches 4; then imem_req=0; instr_out=0x1000, instr_pc=0.
REQ-035 Steady stream, instr_ready=1 continuously -> one instruction retired per cycle after 2-cycle startup latency, with consecutive instr_pc values.
REQ-036 Redirect to 0x40 with 3 entries buffered and one inflight -> next cycle count=0, instr_valid=0; killed data never appears; the first valid output is instr_pc=0x40 three cycles after redirect.
REQ-037 PC_W=8, RESET_PC=0xFE, run=1 -> instr_pc sequence 0xFE, 0xFF, 0x00, 0x01.
REQ-038 reset=0 asserted mid-stream with buffer full -> outputs go to 0 without a clock edge; after release, fetch restarts at RESET_PC.
REQ-039 Random run/instr_ready/redirect for 10k cycles against a scoreboard model -> no overflow, no lost or duplicated instructions, and instr_pc order matches the model.
